i2c_master_arbiter: RTL and testbench

Shares one I2C master (write/read strobe, addr, data_wr in; data_rd, done, ack_error out) between NUM_REQ independent requesters.
- Round-robin arbitration selects one requester.
- The block drives the master's command strobe, waits for completion and routes the read data and ACK status back to the winner.
- Sits between on-chip clients (sensor pollers, config loaders) and the single i2c master instance.

---
 rtl/i2c_master_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters; grant/strobe one cycle after req.
// Optional WAIT watchdog enabled by `define I2C_ARB_TIMEOUT_EN (TIMEOUT_CYCLES).
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int START_HOLD     = 2000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [1:0]             speed_mode,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_ack_error,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic                   m_write,
  output logic                   m_read,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_data_wr,
  output logic [1:0]             m_speed_mode,
  input  logic [7:0]             m_data_rd,
  input  logic                   m_done,
  input  logic                   m_ack_error
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int HW  = $clog2(START_HOLD + 1);
  localparam logic [IW:0]        NREQ_W    = IW1'(NUM_REQ);
  localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_win;
  logic            r_rw;
  logic [HW-1:0]   r_hold;
  logic            r_done_q;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW:0]     w_cand;
  logic            w_rw;
  logic [6:0]      w_addr;
  logic [7:0]      w_data;
  logic            w_done_edge;
  logic            w_to_hit;

  // First requesting index at or above r_rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + IW1'(i);
      if (w_cand >= NREQ_W) w_cand = w_cand - NREQ_W;
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    w_rw   = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_rw   = req_rw[i];
        w_addr = req_addr[7*i +: 7];
        w_data = req_data[8*i +: 8];
      end
    end
  end

  assign w_done_edge  = m_done & ~r_done_q;
  assign m_speed_mode = speed_mode;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt;
  assign w_to_hit = (r_to_cnt == TO_LAST);
`else
  assign w_to_hit    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_win         <= '0;
      r_rw          <= 1'b0;
      r_hold        <= '0;
      r_done_q      <= 1'b0;
      grant         <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_ack_error <= 1'b0;
      busy          <= 1'b0;
      m_write       <= 1'b0;
      m_read        <= 1'b0;
      m_addr        <= '0;
      m_data_wr     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      rsp_timeout   <= 1'b0;
      r_to_cnt      <= '0;
`endif
    end else begin
      r_done_q <= m_done;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win     <= w_win;
            r_rw      <= w_rw;
            m_addr    <= w_addr;
            m_data_wr <= w_data;
            grant     <= ONE_HOT0 << w_win;
            m_write   <= ~w_rw;
            m_read    <= w_rw;
            busy      <= 1'b1;
            r_hold    <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_hold == HOLD_LAST) begin
            m_write <= 1'b0;
            m_read  <= 1'b0;
            r_state <= S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_WAIT: begin
          // Only a fresh 0->1 of m_done counts; a level left high from ISSUE does not
          if (w_done_edge) begin
            rsp_valid     <= grant;
            rsp_data      <= r_rw ? m_data_rd : 8'h00;
            rsp_ack_error <= m_ack_error;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_timeout   <= 1'b0;
`endif
            r_state       <= S_RESP;
          end else if (w_to_hit) begin
            rsp_valid     <= grant;
            rsp_data      <= 8'h00;
            rsp_ack_error <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            rsp_timeout   <= 1'b1;
`endif
            r_state       <= S_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
`endif
        end
        S_RESP: begin
          rsp_valid <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          r_rr_ptr  <= (r_win == LAST_IDX) ? '0 : r_win + IW'(1);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: timestamp-level model plus directed literal checks.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int SH = 2000;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req, req_rw;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_data;
  logic [1:0]     speed_mode;
  logic [N-1:0]   grant, rsp_valid;
  logic [7:0]     rsp_data;
  logic           rsp_ack_error, rsp_timeout, busy, m_write, m_read;
  logic [6:0]     m_addr;
  logic [7:0]     m_data_wr;
  logic [1:0]     m_speed_mode;
  logic [7:0]     m_data_rd   = 8'h00;
  logic           m_ack_error = 1'b0;
  logic           m_done;
  logic           auto_done = 1'b0;
  logic           man_mode  = 1'b0;
  logic           man_done  = 1'b0;

  assign m_done = man_mode ? man_done : auto_done;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NUM_REQ(N), .START_HOLD(SH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .speed_mode(speed_mode), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ack_error(rsp_ack_error), .rsp_timeout(rsp_timeout),
    .busy(busy), .m_write(m_write), .m_read(m_read), .m_addr(m_addr),
    .m_data_wr(m_data_wr), .m_speed_mode(m_speed_mode), .m_data_rd(m_data_rd),
    .m_done(m_done), .m_ack_error(m_ack_error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: one transaction record with timestamps (accept edge, response edge)
  int          cyc     = 0;
  bit          md_act  = 1'b0;
  int          md_acc  = 0;
  int          md_win  = 0;
  int          md_resp = -1;
  bit          md_rwl  = 1'b0;
  int          md_rr   = 0;
  bit          md_pdone = 1'b0;
  logic [6:0]  e_addr  = '0;
  logic [7:0]  e_data  = '0;
  logic [7:0]  h_data  = '0;
  bit          h_ack   = 1'b0;
  bit          h_to    = 1'b0;

  initial begin : model
    bit found;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        md_act = 0; md_rr = 0; md_pdone = 0; md_resp = -1;
        h_data = '0; h_ack = 0; h_to = 0; e_addr = '0; e_data = '0;
      end else begin
        cyc++;
        if (md_act) begin
          if (md_resp >= 0) begin
            if (cyc == md_resp + 1) begin
              md_act = 0;
              md_rr  = (md_win + 1) % N;
            end
          end else if (cyc >= md_acc + SH + 1 && m_done && !md_pdone) begin
            md_resp = cyc;
            h_data  = md_rwl ? m_data_rd : 8'h00;
            h_ack   = m_ack_error;
            h_to    = 0;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (cyc == md_acc + SH + TO) begin
            md_resp = cyc; h_data = 8'h00; h_ack = 1; h_to = 1;
          end
`endif
        end else if (req != '0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            if (!found && req[(md_rr + k) % N]) begin
              found  = 1;
              md_win = (md_rr + k) % N;
            end
          end
          md_act  = 1;
          md_acc  = cyc;
          md_resp = -1;
          md_rwl  = req_rw[md_win];
          e_addr  = req_addr[md_win*7 +: 7];
          e_data  = req_data[md_win*8 +: 8];
        end
        md_pdone = m_done;
      end
    end
  end

  int served[$];

  initial begin : compare
    logic [N-1:0] eg, ev;
    bit es;
    forever begin
      @(negedge clk);
      eg = '0; ev = '0;
      if (md_act) eg[md_win] = 1'b1;
      if (md_act && md_resp >= 0 && cyc == md_resp) ev[md_win] = 1'b1;
      es = md_act && ((cyc - md_acc) < SH);
      chk("grant", grant, eg);
      chk("rsp_valid", rsp_valid, ev);
      chk("busy", busy, md_act);
      chk("m_write", m_write, es && !md_rwl);
      chk("m_read", m_read, es && md_rwl);
      chk("rsp_data", rsp_data, h_data);
      chk("rsp_ack_error", rsp_ack_error, h_ack);
      chk("rsp_timeout", rsp_timeout, h_to);
      chk("m_addr", m_addr, e_addr);
      chk("m_data_wr", m_data_wr, e_data);
      chk("m_speed_mode", m_speed_mode, speed_mode);
      for (int k = 0; k < N; k++) if (rsp_valid[k]) served.push_back(k);
    end
  end

  // Automatic I2C master stand-in: raises done a few cycles after the strobe falls
  bit         rsp_en    = 1'b1;
  int         rsp_delay = 5;
  logic [7:0] rsp_rd    = 8'h00;
  bit         rsp_nack  = 1'b0;

  initial begin : responder
    bit prev = 0;
    bit now;
    int cnt = 0;
    int hold = 0;
    forever begin
      @(posedge clk); #1;
      now = m_write | m_read;
      if (hold > 0) begin
        hold--;
        if (hold == 0) auto_done = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && rsp_en) begin
          m_data_rd   = rsp_rd;
          m_ack_error = rsp_nack;
          auto_done   = 1'b1;
          hold        = 2;
        end
      end
      if (prev && !now && rsp_en) cnt = rsp_delay;
      prev = now;
    end
  end

  task automatic wait_rsp(output logic [N-1:0] got, output int nwr, output int nrd, output int ncyc);
    got = '0; nwr = 0; nrd = 0; ncyc = -1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (m_write) nwr++;
      if (m_read)  nrd++;
      if (rsp_valid != '0) begin
        got  = rsp_valid;
        ncyc = i + 1;
        break;
      end
    end
    if (got == '0) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_rsp: got no rsp_valid expected a pulse within 6000 cycles");
    end
  endtask

  task automatic wait_strobe_fall();
    bit fell = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!(m_write | m_read)) begin fell = 1; break; end
    end
    if (!fell) begin
      n_cmp++; n_fail++;
      $display("FAIL strobe_fall: got strobe still high expected low within 3000 cycles");
    end
  endtask

  initial begin : stim
    logic [N-1:0] got;
    int nwr, nrd, ncyc, fell, ri, base;
    bit seen;
    int exp_order[6] = '{0, 2, 3, 0, 2, 3};

    rst = 1'b0; req = '0; req_rw = '0; speed_mode = 2'b10;
    req_addr = {7'h33, 7'h2A, 7'h1D, 7'h19};
    req_data = {8'hD4, 8'hC3, 8'hB2, 8'h59};
    repeat (3) @(posedge clk); #1;
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_m_write", m_write, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // single write
    req_rw = 4'b0000; req = 4'b0001;
    @(posedge clk); #1;
    chk("wr_latency_m_write", m_write, 1);
    chk("wr_grant", grant, 4'b0001);
    chk("wr_m_addr", m_addr, 7'h19);
    chk("wr_m_data", m_data_wr, 8'h59);
    wait_rsp(got, nwr, nrd, ncyc);
    chk("wr_strobe_len", 1 + nwr, SH);
    chk("wr_no_read", nrd, 0);
    chk("wr_rsp_valid", got, 4'b0001);
    chk("wr_ack", rsp_ack_error, 0);
    req = '0;
    @(posedge clk); #1;
    chk("wr_grant_clear", grant, 0);
    chk("wr_busy_clear", busy, 0);

    // single read
    rsp_rd = 8'hA5; req_rw = 4'b0010; req = 4'b0010;
    wait_rsp(got, nwr, nrd, ncyc);
    chk("rd_rsp_valid", got, 4'b0010);
    chk("rd_data", rsp_data, 8'hA5);
    chk("rd_no_write", nwr, 0);
    chk("rd_strobe_len", nrd, SH);
    req = '0; rsp_rd = 8'h00; req_rw = '0;
    @(posedge clk); #1;

    // NACK, with a non-granted requester toggling mid-transaction
    rsp_nack = 1'b1; req = 4'b0100;
    repeat (30) @(posedge clk); #1;
    req = 4'b0110;
    repeat (20) @(posedge clk); #1;
    req = 4'b0100;
    wait_rsp(got, nwr, nrd, ncyc);
    chk("nack_rsp_valid", got, 4'b0100);
    chk("nack_ack", rsp_ack_error, 1);
    req = '0; rsp_nack = 1'b0;
    @(posedge clk); #1;
    req = 4'b1000;
    wait_rsp(got, nwr, nrd, ncyc);
    chk("ack_rsp_valid", got, 4'b1000);
    chk("ack_clear", rsp_ack_error, 0);
    req = '0;
    @(posedge clk); #1;

    // done held high across WAIT entry must not count
    rsp_en = 1'b0; man_done = 1'b0; man_mode = 1'b1; req = 4'b0001;
    fell = -1; ri = -1; seen = 0; got = '0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (m_write) seen = 1;
      if (i == 10) man_done = 1'b1;
      if (seen && !m_write && fell < 0) fell = i;
      if (fell >= 0 && i == fell + 5) man_done = 1'b0;
      if (fell >= 0 && i == fell + 8) man_done = 1'b1;
      if (rsp_valid != '0) begin ri = i; got = rsp_valid; break; end
    end
    chk("lvl_rsp_valid", got, 4'b0001);
    chk("lvl_rsp_offset", ri - fell, 9);
    req = '0; man_done = 1'b0;
    @(posedge clk); #1;
    man_mode = 1'b0;

    // reset during WAIT
    base = served.size();
    req = 4'b0010;
    @(posedge clk); #1;
    wait_strobe_fall();
    repeat (10) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_m_write", m_write, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_grant", grant, 0);
    req = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1; rsp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_rsp", served.size(), base);
    req = 4'b1001;
    wait_rsp(got, nwr, nrd, ncyc);
    chk("rst_first_winner", got, 4'b0001);
    req = 4'b1000;
    wait_rsp(got, nwr, nrd, ncyc);
    chk("rst_second_winner", got, 4'b1000);
    req = '0;
    @(posedge clk); #1;

    // round-robin with three requesters held high
    base = served.size();
    req = 4'b1101;
    for (int t = 0; t < 6; t++) wait_rsp(got, nwr, nrd, ncyc);
    req = '0;
    @(posedge clk); #1;
    for (int t = 0; t < 6; t++)
      chk("rr_order", (served.size() > base + t) ? served[base + t] : -1, exp_order[t]);

`ifdef I2C_ARB_TIMEOUT_EN
    rsp_en = 1'b0; req_rw = 4'b0010; req = 4'b0010;
    @(posedge clk); #1;
    wait_strobe_fall();
    wait_rsp(got, nwr, nrd, ncyc);
    chk("to_delay", ncyc, TO);
    chk("to_timeout", rsp_timeout, 1);
    chk("to_ack", rsp_ack_error, 1);
    chk("to_data", rsp_data, 0);
    req = '0;
    @(posedge clk); #1;
    chk("to_busy_drop", busy, 0);
    rsp_en = 1'b1;
`endif

    repeat (5) @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
